// File: rtl/seq_generator.sv
// ---------------------------------------------------------------------------
// seq_generator
//
// Sequence generator sitting behind the control unit's sequence interface.
// On a start request it emits seq_num 32-bit words on a valid/ready stream.
// The words either count up from seq_data or come from a 32-bit Galois LFSR
// seeded by seq_data. Completion is reported with a level-held seq_done.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous active-high reset
//   seq_enable  in   1   start request / level hold from control unit
//   rand_flag   in   1   1 = LFSR words, 0 = incrementing words (at start)
//   seq_num     in   8   number of words to emit (at start)
//   seq_data    in   32  seed / start value (at start)
//   out_ready   in   1   downstream accepts out_data this cycle
//   out_valid   out  1   out_data valid
//   out_data    out  32  current sequence word
//   out_idx     out  8   index of current word, 0..seq_num-1
//   busy        out  1   high while words are being emitted
//   seq_done    out  1   sequence complete, held until seq_enable drops
// ---------------------------------------------------------------------------
module seq_generator #(
    parameter logic [31:0] STEP          = 32'h1,
    parameter logic [31:0] LFSR_POLY     = 32'h80200003,
    parameter logic [31:0] ZERO_SEED_SUB = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seq_enable,
    input  logic        rand_flag,
    input  logic [7:0]  seq_num,
    input  logic [31:0] seq_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [7:0]  out_idx,
    output logic        busy,
    output logic        seq_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        mode;       // latched rand_flag
    logic [7:0]  remaining;  // words still to be handed off, incl. current

    // An all-zero LFSR state would lock up, so a zero seed is replaced.
    function automatic logic [31:0] first_word(input logic is_rand,
                                               input logic [31:0] seed);
        if (is_rand && (seed == 32'h0))
            return ZERO_SEED_SUB;
        return seed;
    endfunction

    function automatic logic [31:0] next_word(input logic is_rand,
                                              input logic [31:0] cur);
        if (!is_rand)
            return cur + STEP;
        if (cur[0])
            return (cur >> 1) ^ LFSR_POLY;
        return cur >> 1;
    endfunction

    logic handshake;
    assign handshake = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= 1'b0;
            remaining <= 8'd0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_idx   <= 8'd0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seq_enable) begin
                        mode      <= rand_flag;
                        remaining <= seq_num;
                        out_idx   <= 8'd0;
                        out_data  <= first_word(rand_flag, seq_data);
                        if (seq_num == 8'd0) begin
                            state    <= DONE;
                            seq_done <= 1'b1;
                        end else begin
                            state     <= RUN;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (!seq_enable) begin
                        // Abort: a handshake this cycle was already taken
                        // downstream, nothing more to emit.
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (handshake) begin
                        if (remaining == 8'd1) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            seq_done  <= 1'b1;
                        end else begin
                            remaining <= remaining - 8'd1;
                            out_idx   <= out_idx + 8'd1;
                            out_data  <= next_word(mode, out_data);
                        end
                    end
                end

                DONE: begin
                    // Level handshake: hold done until the request is removed.
                    if (!seq_enable) begin
                        state    <= IDLE;
                        seq_done <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    seq_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_generator.sv
module tb_seq_generator;

    logic        clk;
    logic        rst;
    logic        seq_enable;
    logic        rand_flag;
    logic [7:0]  seq_num;
    logic [31:0] seq_data;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_idx;
    logic        busy;
    logic        seq_done;

    int n_cmp = 0;
    int n_err = 0;

    seq_generator dut (
        .clk        (clk),
        .rst        (rst),
        .seq_enable (seq_enable),
        .rand_flag  (rand_flag),
        .seq_num    (seq_num),
        .seq_data   (seq_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .busy       (busy),
        .seq_done   (seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic r, input logic [7:0] n,
                         input logic [31:0] d);
        seq_enable = 1'b1;
        rand_flag  = r;
        seq_num    = n;
        seq_data   = d;
        tick();
    endtask

    // Check the word currently presented, then advance one clock.
    task automatic expect_word(input string tag, input logic [31:0] d,
                               input logic [7:0] idx);
        chk({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        chk({tag, ".data"},  out_data, d);
        chk({tag, ".idx"},   {24'h0, out_idx}, {24'h0, idx});
        chk({tag, ".busy"},  {31'h0, busy}, 32'h1);
        tick();
    endtask

    task automatic expect_done(input string tag);
        chk({tag, ".done"},  {31'h0, seq_done}, 32'h1);
        chk({tag, ".valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, ".busy"},  {31'h0, busy}, 32'h0);
    endtask

    task automatic release_enable(input string tag);
        seq_enable = 1'b0;
        tick();
        chk({tag, ".done_clr"}, {31'h0, seq_done}, 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        seq_enable = 1'b0;
        rand_flag  = 1'b0;
        seq_num    = 8'd0;
        seq_data   = 32'h0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk("rst.valid", {31'h0, out_valid}, 32'h0);
        chk("rst.data",  out_data, 32'h0);
        chk("rst.idx",   {24'h0, out_idx}, 32'h0);
        chk("rst.busy",  {31'h0, busy}, 32'h0);
        chk("rst.done",  {31'h0, seq_done}, 32'h0);
        rst = 1'b0;
        tick();

        // Incrementing mode
        start(1'b0, 8'd3, 32'hABCDEFAB);
        expect_word("inc0", 32'hABCDEFAB, 8'd0);
        expect_word("inc1", 32'hABCDEFAC, 8'd1);
        expect_word("inc2", 32'hABCDEFAD, 8'd2);
        expect_done("inc.d0");
        tick();
        expect_done("inc.d1");
        release_enable("inc");

        // LFSR mode; later changes to inputs must be ignored
        start(1'b1, 8'd3, 32'h00000001);
        rand_flag = 1'b0;
        seq_data  = 32'h12345678;
        seq_num   = 8'd9;
        expect_word("lfsr0", 32'h00000001, 8'd0);
        expect_word("lfsr1", 32'h80200003, 8'd1);
        expect_word("lfsr2", 32'hC0300002, 8'd2);
        expect_done("lfsr");
        release_enable("lfsr");

        // Zero seed substitution
        start(1'b1, 8'd2, 32'h0);
        expect_word("zs0", 32'h00000001, 8'd0);
        expect_word("zs1", 32'h80200003, 8'd1);
        expect_done("zs");
        release_enable("zs");

        // Backpressure
        out_ready = 1'b0;
        start(1'b0, 8'd4, 32'h10);
        for (int i = 0; i < 4; i++) expect_word("bp_hold", 32'h10, 8'd0);
        out_ready = 1'b1;
        expect_word("bp0", 32'h10, 8'd0);
        expect_word("bp1", 32'h11, 8'd1);
        expect_word("bp2", 32'h12, 8'd2);
        expect_word("bp3", 32'h13, 8'd3);
        expect_done("bp");
        release_enable("bp");

        // Wrap-around
        start(1'b0, 8'd3, 32'hFFFFFFFE);
        expect_word("wrap0", 32'hFFFFFFFE, 8'd0);
        expect_word("wrap1", 32'hFFFFFFFF, 8'd1);
        expect_word("wrap2", 32'h00000000, 8'd2);
        expect_done("wrap");
        release_enable("wrap");

        // Zero length
        start(1'b0, 8'd0, 32'h55);
        expect_done("zero");
        tick();
        expect_done("zero.hold");
        release_enable("zero");

        // Abort after 5 handshakes
        start(1'b0, 8'd50, 32'h100);
        for (int i = 0; i < 5; i++)
            expect_word("ab", 32'h100 + i, i[7:0]);
        seq_enable = 1'b0;
        tick();
        chk("ab.valid", {31'h0, out_valid}, 32'h0);
        chk("ab.done",  {31'h0, seq_done}, 32'h0);
        chk("ab.busy",  {31'h0, busy}, 32'h0);
        tick();
        chk("ab.idle", {31'h0, out_valid}, 32'h0);

        // Reset mid-run after 10 handshakes
        start(1'b0, 8'd50, 32'h200);
        for (int i = 0; i < 10; i++)
            expect_word("rr", 32'h200 + i, i[7:0]);
        rst = 1'b1;
        tick();
        chk("rr.valid", {31'h0, out_valid}, 32'h0);
        chk("rr.data",  out_data, 32'h0);
        chk("rr.idx",   {24'h0, out_idx}, 32'h0);
        chk("rr.busy",  {31'h0, busy}, 32'h0);
        chk("rr.done",  {31'h0, seq_done}, 32'h0);
        seq_enable = 1'b0;
        rst = 1'b0;
        tick();
        chk("rr.idle", {31'h0, out_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
